// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
interface seq_restoring_divider_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
);
  logic         start;
  logic [N-1:0] X;
  logic [M-1:0] D;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [M-1:0] R;
  logic         div_by_zero;

  modport master (
    output start, X, D,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, X, D,
    output busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock through a single
// M+1-bit subtract/restore stage, framed by a start/busy/done handshake.
module seq_restoring_divider #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  seq_restoring_divider_if.slave    bus
);
  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [M:0]    a_q, a_d;
  logic [N-1:0]  qs_q, qs_d;
  logic [M-1:0]  dr_q, dr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic [M-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // One iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
  logic [M+1:0]  a_wide;
  logic [M+1:0]  t;
  logic [M:0]    a_next;
  logic [N-1:0]  qs_next;

  assign a_wide  = {a_q, qs_q[N-1]};
  assign t       = a_wide - (M+2)'(dr_q);
  assign a_next  = t[M+1] ? a_wide[M:0] : t[M:0];
  assign qs_next = {qs_q[N-2:0], ~t[M+1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      qs_q    <= '0;
      dr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qs_q    <= qs_d;
      dr_q    <= dr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qs_d    = qs_q;
    dr_d    = dr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.D != '0) begin
            a_d     = '0;
            qs_d    = bus.X;
            dr_d    = bus.D;
            cnt_d   = CW'(N - 1);
            state_d = RUN;
          end else begin
            // Divide by zero skips the iterations entirely.
            q_d     = '1;
            r_d     = bus.X[M-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        a_d   = a_next;
        qs_d  = qs_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          q_d     = qs_next;
          r_d     = a_next[M-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.Q           = q_q;
  assign bus.R           = r_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed checks of the restoring divider at N=8/M=4 plus an exhaustive
// N=5/M=3 sweep against the integer divide and modulo operators.
module tb_seq_restoring_divider;
  logic clk;
  logic rst;

  int n_checks;
  int n_fail;
  int done_cnt8;
  int k;
  int done_before;

  seq_restoring_divider_if #(.N(8), .M(4)) bus8 ();
  seq_restoring_divider_if #(.N(5), .M(3)) bus5 ();

  seq_restoring_divider #(.N(8), .M(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  seq_restoring_divider #(.N(5), .M(3)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus8.done === 1'b1) done_cnt8++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with busy low; returns at the first negedge after the accepting edge.
  task automatic start8(input logic [7:0] x, input logic [3:0] d);
    bus8.start = 1'b1;
    bus8.X     = x;
    bus8.D     = d;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.X     = 8'($urandom);
    bus8.D     = 4'($urandom);
  endtask

  // k = index of the negedge after the accepting edge at which done is seen (1 = cycle after E0).
  task automatic wait_done8(output int kk);
    kk = 1;
    while (bus8.done !== 1'b1 && kk < 40) begin
      @(negedge clk);
      kk++;
    end
    check("done8_timeout", 32'(kk < 40), 32'd1);
  endtask

  task automatic run8(input string tag, input logic [7:0] x, input logic [3:0] d,
                      input int exp_k, input logic [7:0] eq, input logic [3:0] er,
                      input logic edz);
    int kk;
    start8(x, d);
    wait_done8(kk);
    check({tag, "_lat"}, 32'(kk), 32'(exp_k));
    check({tag, "_Q"}, 32'(bus8.Q), 32'(eq));
    check({tag, "_R"}, 32'(bus8.R), 32'(er));
    check({tag, "_dbz"}, 32'(bus8.div_by_zero), 32'(edz));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
    check({tag, "_idle"}, 32'(bus8.busy), 32'd0);
  endtask

  task automatic run5(input int x, input int d);
    int kk;
    bus5.start = 1'b1;
    bus5.X     = 5'(x);
    bus5.D     = 3'(d);
    @(negedge clk);
    bus5.start = 1'b0;
    kk = 1;
    while (bus5.done !== 1'b1 && kk < 40) begin
      @(negedge clk);
      kk++;
    end
    check("done5_timeout", 32'(kk < 40), 32'd1);
    if (d == 0) begin
      check("sweep_Q_dz", 32'(bus5.Q), 32'd31);
      check("sweep_R_dz", 32'(bus5.R), 32'(x % 8));
      check("sweep_dbz1", 32'(bus5.div_by_zero), 32'd1);
    end else begin
      check("sweep_Q", 32'(bus5.Q), 32'(x / d));
      check("sweep_R", 32'(bus5.R), 32'(x % d));
      check("sweep_dbz0", 32'(bus5.div_by_zero), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    done_cnt8  = 0;
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.X     = '0;
    bus8.D     = '0;
    bus5.start = 1'b0;
    bus5.X     = '0;
    bus5.D     = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_Q", 32'(bus8.Q), 32'd0);
    check("rst_R", 32'(bus8.R), 32'd0);
    check("rst_dbz", 32'(bus8.div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 200 / 7: done 8 edges after accept (negedge index 9)
    run8("d200_7", 8'd200, 4'd7, 9, 8'd28, 4'd4, 1'b0);

    // 255 / 15, then hold, then 5 / 9
    run8("d255_15", 8'd255, 4'd15, 9, 8'd17, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_idle_Q", 32'(bus8.Q), 32'd17);
    check("hold_idle_R", 32'(bus8.R), 32'd0);
    start8(8'd5, 4'd9);
    repeat (3) @(negedge clk);
    check("hold_run_busy", 32'(bus8.busy), 32'd1);
    check("hold_run_Q", 32'(bus8.Q), 32'd17);
    check("hold_run_R", 32'(bus8.R), 32'd0);
    wait_done8(k);
    check("d5_9_Q", 32'(bus8.Q), 32'd0);
    check("d5_9_R", 32'(bus8.R), 32'd5);
    @(negedge clk);

    // Divide by zero, then a normal divide clears the flag
    run8("dz_5A", 8'h5A, 4'd0, 1, 8'hFF, 4'hA, 1'b1);
    run8("d10_3", 8'd10, 4'd3, 9, 8'd3, 4'd1, 1'b0);

    // Start pulsed while running is ignored
    done_before = done_cnt8;
    start8(8'd100, 4'd3);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.X     = 8'd1;
    bus8.D     = 4'd1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(k);
    check("ign_Q", 32'(bus8.Q), 32'd33);
    check("ign_R", 32'(bus8.R), 32'd1);
    repeat (12) @(negedge clk);
    check("ign_single_done", 32'(done_cnt8 - done_before), 32'd1);
    check("ign_idle", 32'(bus8.busy), 32'd0);

    // Asynchronous reset mid-run aborts with no done pulse
    start8(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    done_before = done_cnt8;
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus8.busy), 32'd0);
    check("arst_done", 32'(bus8.done), 32'd0);
    check("arst_Q", 32'(bus8.Q), 32'd0);
    check("arst_R", 32'(bus8.R), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_no_done", 32'(done_cnt8 - done_before), 32'd0);
    run8("d77_5", 8'd77, 4'd5, 9, 8'd15, 4'd2, 1'b0);

    // Exhaustive N=5, M=3 sweep
    for (int x = 0; x < 32; x++)
      for (int d = 0; d < 8; d++)
        run5(x, d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
